// File: rtl/equiv_compare_monitor_if.sv
// Stimulus/compare bus between the post-route harness and the equivalence monitor.
// A vector is accepted on a rising edge where vec_valid and vec_ready are both high.
// vec_valid may stay high while vec_ready is low, and is ignored then. The harness keeps
// golden_out/netlist_out showing that vector's results until the compare edge.
interface equiv_compare_monitor_if #(
    parameter int WIDTH = 32
);
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] golden_out;
    logic [WIDTH-1:0] netlist_out;

    modport master (
        output vec_valid,
        output golden_out,
        output netlist_out,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  golden_out,
        input  netlist_out,
        output vec_ready
    );
endinterface

// File: rtl/equiv_compare_monitor.sv
// Output-equivalence checker: paces vectors, waits SETTLE cycles after each one, then
// compares the golden and netlist buses, counts mismatches and keeps the first failure.
module equiv_compare_monitor #(
    parameter int WIDTH       = 32,
    parameter int NUM_VECTORS = 1000,
    parameter int SETTLE      = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    equiv_compare_monitor_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       vec_cnt,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic                   first_valid,
    output logic [CNT_W-1:0]       first_idx,
    output logic [WIDTH-1:0]       first_golden,
    output logic [WIDTH-1:0]       first_netlist,
    output logic [1:0]             dbg_state_o
);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [SET_W-1:0] settle_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             first_valid_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] mm_cnt_q;
    logic [CNT_W-1:0] first_idx_q;
    logic [WIDTH-1:0] first_golden_q;
    logic [WIDTH-1:0] first_netlist_q;

    logic             mismatch;
    logic             last_vec;
    logic [CNT_W-1:0] vec_cnt_d;
    logic [CNT_W-1:0] mm_cnt_d;

    always_comb begin
        mismatch  = (bus.golden_out != bus.netlist_out);
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        mm_cnt_d  = mm_cnt_q;
        // Saturate rather than wrap so a long bad run never reads back as clean.
        if (mismatch && (mm_cnt_q != {CNT_W{1'b1}})) begin
            mm_cnt_d = mm_cnt_q + CNT_W'(1);
        end
        last_vec  = (vec_cnt_d == CNT_W'(NUM_VECTORS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            settle_q        <= '0;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            first_valid_q   <= 1'b0;
            vec_cnt_q       <= '0;
            mm_cnt_q        <= '0;
            first_idx_q     <= '0;
            first_golden_q  <= '0;
            first_netlist_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q         <= S_ARM;
                        ready_q         <= 1'b1;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        first_valid_q   <= 1'b0;
                        vec_cnt_q       <= '0;
                        mm_cnt_q        <= '0;
                        first_idx_q     <= '0;
                        first_golden_q  <= '0;
                        first_netlist_q <= '0;
                    end
                end
                S_ARM: begin
                    if (bus.vec_valid) begin
                        state_q  <= S_SETTLE;
                        ready_q  <= 1'b0;
                        settle_q <= SET_W'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        vec_cnt_q <= vec_cnt_d;
                        mm_cnt_q  <= mm_cnt_d;
                        if (mismatch && !first_valid_q) begin
                            first_valid_q   <= 1'b1;
                            first_idx_q     <= vec_cnt_q;
                            first_golden_q  <= bus.golden_out;
                            first_netlist_q <= bus.netlist_out;
                        end
                        if (last_vec) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mm_cnt_d == '0);
                        end else begin
                            state_q <= S_ARM;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_ready   = ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign vec_cnt         = vec_cnt_q;
    assign mismatch_cnt    = mm_cnt_q;
    assign first_valid     = first_valid_q;
    assign first_idx       = first_idx_q;
    assign first_golden    = first_golden_q;
    assign first_netlist   = first_netlist_q;
    assign dbg_state_o     = state_q;
endmodule
